// File: rtl/sobel_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sobel_pkg
//  Purpose  : Shared defaults and type definitions for the Sobel write-back
//             path: image geometry, saturation width, border fill value,
//             top-level state encoding and border-sequence phase encoding.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package sobel_pkg;

   localparam int unsigned DEF_WIDTH  = 256;
   localparam int unsigned DEF_HEIGHT = 256;
   localparam int unsigned DEF_RC_W   = 8;
   localparam int unsigned DEF_IN_W   = 11;
   localparam int unsigned DEF_AW     = 16;

   // Output pixels are saturated to this many bits.
   localparam int unsigned SAT_W = 8;

   localparam logic [SAT_W-1:0] DEF_BORDER_VALUE = 8'd0;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      FILL   = 2'd2,
      DONE   = 2'd3
   } state_t;

   // Border walk: full top row, full bottom row, then left/right pairs.
   typedef enum logic [1:0] {
      PH_TOP    = 2'd0,
      PH_BOTTOM = 2'd1,
      PH_SIDES  = 2'd2
   } fill_phase_t;

endpackage
`default_nettype wire

// File: rtl/border_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module   : border_addr_gen
//  Purpose  : Walks the image border one pixel per Step:
//             row 0 (all columns), row HEIGHT-1 (all columns), then for each
//             inner row r: (r,0) followed by (r,WIDTH-1).
//  Ports    : CLK    - clock
//             Reset  - synchronous active-high reset
//             Start  - load the first border position (0,0)
//             Step   - advance to the next border position
//             Row    - current border row
//             Column - current border column
//             Last   - current position is the final border pixel
//  Revision : 1.0 - initial release
// ============================================================================
module border_addr_gen
   import sobel_pkg::*;
#(
   parameter int unsigned WIDTH  = DEF_WIDTH,
   parameter int unsigned HEIGHT = DEF_HEIGHT,
   parameter int unsigned RC_W   = DEF_RC_W
) (
   input  logic            CLK,
   input  logic            Reset,
   input  logic            Start,
   input  logic            Step,
   output logic [RC_W-1:0] Row,
   output logic [RC_W-1:0] Column,
   output logic            Last
);

   localparam logic [RC_W-1:0] c_lastCol     = RC_W'(WIDTH - 1);
   localparam logic [RC_W-1:0] c_lastRow     = RC_W'(HEIGHT - 1);
   localparam logic [RC_W-1:0] c_lastSideRow = RC_W'(HEIGHT - 2);
   // Images only two rows tall have no side pixels; the walk ends on row 1.
   localparam bit              c_hasSides    = (HEIGHT > 2);

   fill_phase_t r_phase;

   always_comb begin
      Last = 1'b0;
      if (c_hasSides)
         Last = (r_phase == PH_SIDES) && (Row == c_lastSideRow) && (Column == c_lastCol);
      else
         Last = (r_phase == PH_BOTTOM) && (Column == c_lastCol);
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         r_phase <= PH_TOP;
         Row     <= '0;
         Column  <= '0;
      end else if (Start) begin
         r_phase <= PH_TOP;
         Row     <= '0;
         Column  <= '0;
      end else if (Step && !Last) begin
         unique case (r_phase)
            PH_TOP: begin
               if (Column == c_lastCol) begin
                  r_phase <= PH_BOTTOM;
                  Row     <= c_lastRow;
                  Column  <= '0;
               end else begin
                  Column  <= Column + 1'b1;
               end
            end
            PH_BOTTOM: begin
               if (Column == c_lastCol) begin
                  r_phase <= PH_SIDES;
                  Row     <= RC_W'(1);
                  Column  <= '0;
               end else begin
                  Column  <= Column + 1'b1;
               end
            end
            PH_SIDES: begin
               // Left edge then right edge of the same row, then next row.
               if (Column == '0) begin
                  Column <= c_lastCol;
               end else begin
                  Row    <= Row + 1'b1;
                  Column <= '0;
               end
            end
            default: r_phase <= PH_TOP;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/pixel_storer.sv
`default_nettype none
// ============================================================================
//  Module   : pixel_storer
//  Purpose  : Write-back stage of the Sobel datapath. Saturates incoming
//             gradient magnitudes to 8 bits and writes them to the output
//             image at row*WIDTH+column; after the last interior pixel it
//             paints the border with BORDER_VALUE and reports completion.
//  Ports    : CLK       - clock, rising edge
//             Reset     - synchronous active-high reset
//             Enable    - start / stream-pause control
//             DataIn    - processed pixel magnitude
//             In_Row    - row of DataIn
//             In_Column - column of DataIn
//             isReady   - DataIn / coordinates valid
//             isEnd     - marks the last interior pixel (with isReady)
//             WrEn      - memory write strobe
//             WrAddr    - raster write address
//             WrData    - pixel value to write
//             Busy      - streaming or filling
//             Done      - image complete (sticky)
//             Overrun   - data offered after streaming ended (sticky)
//  Revision : 1.0 - initial release
// ============================================================================
module pixel_storer
   import sobel_pkg::*;
#(
   parameter int unsigned      WIDTH        = DEF_WIDTH,
   parameter int unsigned      HEIGHT       = DEF_HEIGHT,
   parameter int unsigned      RC_W         = DEF_RC_W,
   parameter int unsigned      IN_W         = DEF_IN_W,
   parameter int unsigned      AW           = DEF_AW,
   parameter logic [SAT_W-1:0] BORDER_VALUE = DEF_BORDER_VALUE
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic             Enable,
   input  logic [IN_W-1:0]  DataIn,
   input  logic [RC_W-1:0]  In_Row,
   input  logic [RC_W-1:0]  In_Column,
   input  logic             isReady,
   input  logic             isEnd,
   output logic             WrEn,
   output logic [AW-1:0]    WrAddr,
   output logic [SAT_W-1:0] WrData,
   output logic             Busy,
   output logic             Done,
   output logic             Overrun
);

   localparam int unsigned c_satMax = (2 ** SAT_W) - 1;

   state_t r_state;

   logic             w_accept;
   logic             w_inRange;
   logic [31:0]      w_streamAddr;
   logic [31:0]      w_fillAddr;
   logic [SAT_W-1:0] w_satData;
   logic [RC_W-1:0]  w_fillRow;
   logic [RC_W-1:0]  w_fillCol;
   logic             w_fillLast;

   assign w_accept     = (r_state == STREAM) && Enable && isReady;
   assign w_inRange    = (32'(In_Row) < HEIGHT) && (32'(In_Column) < WIDTH);
   assign w_streamAddr = 32'(In_Row) * WIDTH + 32'(In_Column);
   assign w_fillAddr   = 32'(w_fillRow) * WIDTH + 32'(w_fillCol);
   assign w_satData    = (DataIn > IN_W'(c_satMax)) ? {SAT_W{1'b1}} : DataIn[SAT_W-1:0];

   // Loaded on the isEnd acceptance so the first border address is ready
   // on the very next edge, keeping WrEn continuous into the fill.
   border_addr_gen #(
      .WIDTH  (WIDTH),
      .HEIGHT (HEIGHT),
      .RC_W   (RC_W)
   ) u_borderAddrGen (
      .CLK    (CLK),
      .Reset  (Reset),
      .Start  (w_accept && isEnd),
      .Step   (r_state == FILL),
      .Row    (w_fillRow),
      .Column (w_fillCol),
      .Last   (w_fillLast)
   );

   always_ff @(posedge CLK) begin
      if (Reset) begin
         r_state <= IDLE;
         WrEn    <= 1'b0;
         WrAddr  <= '0;
         WrData  <= '0;
         Busy    <= 1'b0;
         Done    <= 1'b0;
         Overrun <= 1'b0;
      end else begin
         WrEn <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (Enable) begin
                  r_state <= STREAM;
                  Busy    <= 1'b1;
               end
            end
            STREAM: begin
               if (w_accept) begin
                  // Out-of-image coordinates are silently dropped.
                  if (w_inRange) begin
                     WrEn   <= 1'b1;
                     WrAddr <= w_streamAddr[AW-1:0];
                     WrData <= w_satData;
                  end
                  if (isEnd)
                     r_state <= FILL;
               end
            end
            FILL: begin
               WrEn   <= 1'b1;
               WrAddr <= w_fillAddr[AW-1:0];
               WrData <= BORDER_VALUE;
               if (isReady)
                  Overrun <= 1'b1;
               if (w_fillLast) begin
                  r_state <= DONE;
                  Busy    <= 1'b0;
                  Done    <= 1'b1;
               end
            end
            DONE: begin
               if (isReady)
                  Overrun <= 1'b1;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pixel_storer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pixel_storer
//  Purpose  : Self-checking bench for pixel_storer against a behavioural
//             model of the write-back rules (mode, fill queue, sticky flags).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pixel_storer;

   localparam int W      = 256;
   localparam int H      = 256;
   localparam int FILL_N = 2 * W + 2 * (H - 2);

   logic        CLK = 1'b0;
   logic        Reset, Enable, isReady, isEnd;
   logic [10:0] DataIn;
   logic [7:0]  In_Row, In_Column;
   logic        WrEn;
   logic [15:0] WrAddr;
   logic [7:0]  WrData;
   logic        Busy, Done, Overrun;

   pixel_storer dut (
      .CLK       (CLK),
      .Reset     (Reset),
      .Enable    (Enable),
      .DataIn    (DataIn),
      .In_Row    (In_Row),
      .In_Column (In_Column),
      .isReady   (isReady),
      .isEnd     (isEnd),
      .WrEn      (WrEn),
      .WrAddr    (WrAddr),
      .WrData    (WrData),
      .Busy      (Busy),
      .Done      (Done),
      .Overrun   (Overrun)
   );

   always #5 CLK = ~CLK;

   int nCompared   = 0;
   int nMismatched = 0;

   // Reference model: 0 idle, 1 stream, 2 fill, 3 done.
   int fillQ[$];
   int mMode     = 0;
   int mFillIdx  = 0;
   bit mOverrun  = 1'b0;

   task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nCompared++;
      if (obs !== exp) begin
         nMismatched++;
         $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Drive one cycle of inputs, advance the model, then check outputs.
   task automatic cycle(input bit rst, input bit en, input bit rdy, input bit endF,
                        input int row, input int col, input int data);
      bit expWr;
      int expAddr, expData, spot;
      bit lastFill;
      expWr = 0; expAddr = 0; expData = 0; lastFill = 0; spot = -1;
      Reset     = rst;
      Enable    = en;
      isReady   = rdy;
      isEnd     = endF;
      In_Row    = row[7:0];
      In_Column = col[7:0];
      DataIn    = data[10:0];
      @(posedge CLK);
      #1;
      if (rst) begin
         mMode    = 0;
         mOverrun = 0;
      end else begin
         case (mMode)
            0: if (en) mMode = 1;
            1: if (en && rdy) begin
                  if (row < H && col < W) begin
                     expWr   = 1;
                     expAddr = row * W + col;
                     expData = (data > 255) ? 255 : data;
                  end
                  if (endF) begin
                     mMode    = 2;
                     mFillIdx = 0;
                  end
               end
            2: begin
                  expWr   = 1;
                  expAddr = fillQ[mFillIdx];
                  expData = 0;
                  case (mFillIdx)
                     0:          spot = 32'h0000;
                     255:        spot = 32'h00FF;
                     256:        spot = 32'hFF00;
                     512:        spot = 32'h0100;
                     513:        spot = 32'h01FF;
                     FILL_N - 1: spot = 32'hFEFF;
                     default:    spot = -1;
                  endcase
                  mFillIdx++;
                  if (rdy) mOverrun = 1;
                  if (mFillIdx == FILL_N) begin
                     mMode    = 3;
                     lastFill = 1;
                  end
               end
            3: if (rdy) mOverrun = 1;
            default: mMode = 0;
         endcase
      end
      checkEq("WrEn", 32'(WrEn), 32'(expWr));
      if (expWr) begin
         checkEq("WrAddr", 32'(WrAddr), 32'(expAddr));
         checkEq("WrData", 32'(WrData), 32'(expData));
      end
      if (spot >= 0)
         checkEq("fillSpotAddr", 32'(WrAddr), 32'(spot));
      // The flag update on the final border write itself is left unchecked.
      if (!lastFill) begin
         checkEq("Busy", 32'(Busy), 32'(mMode == 1 || mMode == 2));
         checkEq("Done", 32'(Done), 32'(mMode == 3));
      end
      checkEq("Overrun", 32'(Overrun), 32'(mOverrun));
      if (rst) begin
         checkEq("WrAddrRst", 32'(WrAddr), 32'd0);
         checkEq("WrDataRst", 32'(WrData), 32'd0);
      end
   endtask

   task automatic randStream(input int n);
      for (int i = 0; i < n; i++) begin
         bit en, rdy, endF;
         en   = ($urandom % 4) != 0;
         rdy  = 1'($urandom % 2);
         endF = rdy ? 1'b0 : 1'($urandom % 2);   // isEnd without isReady
         cycle(0, en, rdy, endF, int'($urandom_range(1, 254)),
               int'($urandom_range(1, 254)), int'($urandom_range(0, 2047)));
      end
   endtask

   // Run the border fill; optional isReady pulses and optional reset point.
   task automatic runFill(input bit pulses, input int resetAt);
      for (int i = 0; i < FILL_N + 5 && mMode == 2; i++) begin
         if (i == resetAt)
            cycle(1, 0, 0, 0, 0, 0, 0);
         else
            cycle(0, 1'($urandom % 2),
                  pulses ? ((i == 100) || ($urandom % 16 == 0)) : 1'b0,
                  1'($urandom % 2), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 255)), int'($urandom_range(0, 2047)));
      end
   endtask

   initial begin
      for (int c = 0; c < W; c++) fillQ.push_back(c);
      for (int c = 0; c < W; c++) fillQ.push_back((H - 1) * W + c);
      for (int r = 1; r < H - 1; r++) begin
         fillQ.push_back(r * W);
         fillQ.push_back(r * W + W - 1);
      end

      // Reset, then idle with stray isReady that must be ignored.
      repeat (3) cycle(1, 0, 0, 0, 0, 0, 0);
      repeat (10) cycle(0, 0, 1'($urandom % 2), 0, 5, 5, 7);

      // First image: directed pixels, random stream, pause, end, fill.
      cycle(0, 1, 0, 0, 0, 0, 0);
      cycle(0, 1, 1, 0, 1, 1, 100);
      cycle(0, 1, 1, 0, 254, 254, 2040);
      cycle(0, 1, 1, 0, 254, 254, 255);
      cycle(0, 1, 1, 0, 254, 254, 256);
      randStream(60);
      repeat (5) cycle(0, 0, 1, 0, 10, 20, 300);
      cycle(0, 1, 1, 1, 254, 254, int'($urandom_range(0, 2047)));
      runFill(0, -1);
      repeat (3) cycle(0, 1'($urandom % 2), 0, 0, 0, 0, 0);
      cycle(0, 1, 1, 0, 3, 3, 3);                       // isReady in DONE
      repeat (2) cycle(0, 0, 0, 0, 0, 0, 0);

      // Second image: isReady pulses during fill.
      cycle(1, 0, 0, 0, 0, 0, 0);
      cycle(0, 1, 0, 0, 0, 0, 0);
      randStream(40);
      cycle(0, 1, 1, 1, 128, 7, 1000);
      runFill(1, -1);
      repeat (3) cycle(0, 0, 0, 0, 0, 0, 0);

      // Third image: reset in the middle of the fill, then restart.
      cycle(1, 0, 0, 0, 0, 0, 0);
      cycle(0, 1, 0, 0, 0, 0, 0);
      randStream(20);
      cycle(0, 1, 1, 1, 254, 254, 9);
      runFill(1, 399);
      repeat (2) cycle(0, 0, 0, 0, 0, 0, 0);
      cycle(0, 1, 0, 0, 0, 0, 0);
      cycle(0, 1, 1, 0, 2, 3, 77);
      randStream(30);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pixel_storer.md
Name: pixel_storer

Overview:
- Write-back end of the Sobel datapath; the mirror of the window loader.
- Accepts processed gradient magnitudes, each tagged with its row/column from the loader's coordinate stream.
- Saturates each magnitude to 8 bits and writes it to the output image memory at its raster address.
- After the final interior pixel, fills the image border with a constant, then signals completion.

Parameters:
- WIDTH, 256, image width in pixels
- HEIGHT, 256, image height in pixels
- RC_W, 8, row/column coordinate width
- IN_W, 11, input magnitude width (|Gx|+|Gy| max 2040)
- AW, 16, write address width (must satisfy 2^AW >= WIDTH*HEIGHT)
- BORDER_VALUE, 8'd0, value written to border pixels

Ports:
- CLK  in  1  clock, all logic on rising edge
- Reset  in  1  synchronous active-high reset
- Enable  in  1  start / stream-pause control
- DataIn  in  IN_W  processed pixel magnitude
- In_Row  in  RC_W  row of DataIn
- In_Column  in  RC_W  column of DataIn
- isReady  in  1  DataIn/In_Row/In_Column valid this cycle
- isEnd  in  1  qualifies the last interior pixel (meaningful only with isReady)
- WrEn  out  1  memory write strobe
- WrAddr  out  AW  raster address, row*WIDTH+column
- WrData  out  8  pixel value to write
- Busy  out  1  high in STREAM and FILL
- Done  out  1  image complete, sticky until Reset
- Overrun  out  1  sticky: isReady seen in FILL or DONE

Behaviour:
- Clock and reset are decided: one clock CLK; Reset is synchronous and active-high.
- Reset, sampled at the CLK edge, returns the block to IDLE with WrEn=0, WrAddr=0, WrData=0, Busy=0, Done=0, Overrun=0, and fill counter 0.
  - Applies mid-operation: no write occurs on the cycle after Reset is sampled.
- All outputs are registered. Write latency is 1 cycle from the accepting edge to WrEn/WrAddr/WrData.
- IDLE:
  - Enable=1 -> STREAM, Busy=1.
  - isReady is ignored in IDLE and does not set Overrun.
- STREAM:
  - A pixel is accepted on an edge where Enable=1 and isReady=1.
  - On acceptance: WrEn=1, WrAddr=In_Row*WIDTH+In_Column (truncated to AW), WrData=(DataIn>255)?255:DataIn[7:0].
  - Coordinates with In_Row>=HEIGHT or In_Column>=WIDTH: pixel dropped, WrEn=0, no error.
  - Enable=0: inputs ignored, WrEn=0, state held; resumes when Enable returns to 1.
  - Accepted pixel with isEnd=1 is written, then state -> FILL. isEnd without isReady is ignored.
- FILL:
  - Runs one write per cycle regardless of Enable. WrEn=1, WrData=BORDER_VALUE.
  - Address order:
    - row 0, columns 0..WIDTH-1
    - row HEIGHT-1, columns 0..WIDTH-1
    - then for r=1..HEIGHT-2: (r,0), then (r,WIDTH-1)
  - Length is 2*WIDTH+2*(HEIGHT-2) writes (1020 at defaults).
  - First FILL write is on the cycle after the isEnd pixel write, so WrEn stays high continuously.
  - isReady=1 in FILL: input ignored, Overrun<=1, fill sequence unaffected.
  - After the last fill write -> DONE.
- DONE:
  - WrEn=0, Busy=0, Done=1, held until Reset.
  - isReady=1 sets Overrun.
  - Enable has no effect.
- Busy is 1 exactly while state is STREAM or FILL.
- Any write in FILL overrides a stream value previously written to the same address. This cannot occur with loader-generated interior coordinates.

Decomposition:
- Shared package sobel_pkg: default WIDTH/HEIGHT/RC_W/AW, BORDER_VALUE, state encoding {IDLE, STREAM, FILL, DONE}, saturation width constant 8.
- One sub-module, border_addr_gen:
  - Inputs: CLK, Reset, Start, Step.
  - Outputs: row/column, Last.
  - Implements the FILL address sequence counter.
- Top level holds the FSM, saturation, address multiply/concat, and output registers.

Test Plan:
1. Reset=1 for 3 cycles, then Enable=0 for 10 cycles -> all outputs 0 throughout, Busy=0.
2. Enable=1, then isReady=1, In_Row=1, In_Column=1, DataIn=100 -> next cycle WrEn=1, WrAddr=16'h0101, WrData=8'd100, Busy=1.
3. isReady=1 at (254,254) with DataIn=2040 -> WrAddr=16'hFEFE, WrData=8'd255. DataIn=255 -> WrData=255. DataIn=256 -> WrData=255.
4. Accept (254,254) with isEnd=1 -> that write, then exactly 1020 consecutive WrEn cycles with WrData=0:
   - 1st addr 16'h0000, 256th 16'h00FF, 257th 16'hFF00, 513th 16'h0100, 514th 16'h01FF, last 16'hFEFF.
   - Next cycle: Done=1, Busy=0, WrEn=0.
5. Enable=0 for 5 cycles mid-STREAM with isReady=1 -> no writes. isReady pulse during FILL -> Overrun=1, fill address sequence identical to scenario 4.
6. Reset=1 at fill write #400 -> next cycle WrEn=0, Busy=0, Done=0, Overrun=0. Re-Enable -> normal stream restart.
